// File: rtl/relay_instruction_sequencer_if.sv
// Control bundle between the relay CPU sequencer and the rest of the machine.
// The master side is the sequencer; the slave side is the datapath/clock source.
interface relay_instruction_sequencer_if #(
    parameter int unsigned OPCODE_W = 8
);
    logic                run;
    logic [OPCODE_W-1:0] instr;
    logic                cond_true;
    logic [4:0]          cycle_state;
    logic                halted;
    logic [1:0]          addr_sel;
    logic                mem_read;
    logic                mem_write;
    logic                ir_load;
    logic                inc_load;
    logic                pc_load;
    logic                pc_src;
    logic                src_drive;
    logic                dst_load;
    logic                m_load;
    logic                j_load;
    logic                instr_done;

    modport master (
        input  run, instr, cond_true,
        output cycle_state, halted, addr_sel, mem_read, mem_write, ir_load,
               inc_load, pc_load, pc_src, src_drive, dst_load, m_load, j_load,
               instr_done
    );

    modport slave (
        output run, instr, cond_true,
        input  cycle_state, halted, addr_sel, mem_read, mem_write, ir_load,
               inc_load, pc_load, pc_src, src_drive, dst_load, m_load, j_load,
               instr_done
    );
endinterface

// File: rtl/relay_instruction_sequencer.sv
// Cycle-level sequencer for the relay CPU: steps states 1..24 through fetch,
// PC increment and execute for each instruction class and emits registered strobes.
module relay_instruction_sequencer #(
    parameter int unsigned         OPCODE_W    = 8,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = 8'b1010_1110
) (
    input logic                           clock,
    input logic                           reset,
    relay_instruction_sequencer_if.master bus
);

    typedef enum logic {M_HALTED, M_RUN} mode_t;
    typedef enum logic [2:0] {C_EXEC8, C_NOP, C_HALT, C_LOAD, C_STORE, C_GOTO} class_t;

    mode_t      r_mode, w_mode_nxt;
    logic [4:0] r_step, w_step_nxt;
    class_t     r_class, w_class_nxt;
    logic       r_cond, w_cond_nxt;
    logic       w_last;

    logic       r_halted, w_halted;
    logic [1:0] r_addr_sel, w_addr_sel;
    logic       r_mem_read, w_mem_read;
    logic       r_mem_write, w_mem_write;
    logic       r_ir_load, w_ir_load;
    logic       r_inc_load, w_inc_load;
    logic       r_pc_load, w_pc_load;
    logic       r_pc_src, w_pc_src;
    logic       r_src_drive, w_src_drive;
    logic       r_dst_load, w_dst_load;
    logic       r_m_load, w_m_load;
    logic       r_j_load, w_j_load;
    logic       r_instr_done, w_instr_done;

    function automatic class_t decode(input logic [OPCODE_W-1:0] op);
        if (op == HALT_OPCODE) return C_HALT;
        casez (op[OPCODE_W-1 -: 4])
            4'b00??, 4'b01??, 4'b1000: return C_EXEC8;
            4'b1001:                   return op[3] ? C_STORE : C_LOAD;
            4'b11??:                   return C_GOTO;
            default:                   return C_NOP;
        endcase
    endfunction

    function automatic logic [4:0] last_step(input class_t c);
        case (c)
            C_GOTO:          return 5'd24;
            C_LOAD, C_STORE: return 5'd12;
            default:         return 5'd8;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode       <= M_HALTED;
            r_step       <= '0;
            r_class      <= C_NOP;
            r_cond       <= 1'b0;
            r_halted     <= 1'b1;
            r_addr_sel   <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_ir_load    <= 1'b0;
            r_inc_load   <= 1'b0;
            r_pc_load    <= 1'b0;
            r_pc_src     <= 1'b0;
            r_src_drive  <= 1'b0;
            r_dst_load   <= 1'b0;
            r_m_load     <= 1'b0;
            r_j_load     <= 1'b0;
            r_instr_done <= 1'b0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_step       <= w_step_nxt;
            r_class      <= w_class_nxt;
            r_cond       <= w_cond_nxt;
            r_halted     <= w_halted;
            r_addr_sel   <= w_addr_sel;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_ir_load    <= w_ir_load;
            r_inc_load   <= w_inc_load;
            r_pc_load    <= w_pc_load;
            r_pc_src     <= w_pc_src;
            r_src_drive  <= w_src_drive;
            r_dst_load   <= w_dst_load;
            r_m_load     <= w_m_load;
            r_j_load     <= w_j_load;
            r_instr_done <= w_instr_done;
        end
    end

    // Strobes are computed from the *next* state so they register alongside it
    // and are a pure function of the state actually being entered.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_step_nxt  = r_step;
        w_class_nxt = r_class;
        w_cond_nxt  = r_cond;
        w_last      = (r_mode == M_RUN) && (r_step == last_step(r_class));

        case (r_mode)
            M_HALTED: begin
                if (bus.run) begin
                    w_mode_nxt = M_RUN;
                    w_step_nxt = 5'd1;
                end
            end
            default: begin
                if (r_step == 5'd4)  w_class_nxt = decode(bus.instr);
                if (r_step == 5'd19) w_cond_nxt  = bus.cond_true;
                if (w_last) begin
                    if (r_class == C_HALT) begin
                        w_mode_nxt = M_HALTED;
                        w_step_nxt = '0;
                    end else begin
                        w_step_nxt = 5'd1;
                    end
                end else begin
                    w_step_nxt = r_step + 5'd1;
                end
            end
        endcase

        w_halted     = (w_mode_nxt == M_HALTED);
        w_addr_sel   = '0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_load    = 1'b0;
        w_inc_load   = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_src     = 1'b0;
        w_src_drive  = 1'b0;
        w_dst_load   = 1'b0;
        w_m_load     = 1'b0;
        w_j_load     = 1'b0;
        w_instr_done = (w_mode_nxt == M_RUN) && (w_step_nxt == last_step(w_class_nxt));

        if (w_step_nxt inside {[5'd1:5'd3]}) w_addr_sel = 2'd1;
        if (w_step_nxt inside {[5'd2:5'd3]}) w_mem_read = 1'b1;
        if (w_step_nxt == 5'd3) begin
            w_ir_load  = 1'b1;
            w_inc_load = 1'b1;
        end
        if (w_step_nxt inside {[5'd5:5'd6]}) w_pc_load = 1'b1;

        case (w_class_nxt)
            C_EXEC8: begin
                if (w_step_nxt inside {[5'd5:5'd7]}) w_src_drive = 1'b1;
                if (w_step_nxt == 5'd7)              w_dst_load  = 1'b1;
            end
            C_LOAD: begin
                if (w_step_nxt inside {[5'd9:5'd11]})  w_addr_sel = 2'd2;
                if (w_step_nxt inside {[5'd10:5'd11]}) w_mem_read = 1'b1;
                if (w_step_nxt == 5'd11)               w_dst_load = 1'b1;
            end
            C_STORE: begin
                if (w_step_nxt inside {[5'd9:5'd11]}) begin
                    w_addr_sel  = 2'd2;
                    w_src_drive = 1'b1;
                end
                if (w_step_nxt == 5'd10) w_mem_write = 1'b1;
            end
            C_GOTO: begin
                if (w_step_nxt inside {[5'd9:5'd11], [5'd14:5'd16]}) w_addr_sel = 2'd1;
                if (w_step_nxt inside {[5'd10:5'd11], [5'd15:5'd16]}) w_mem_read = 1'b1;
                if (w_step_nxt == 5'd11) begin
                    w_m_load   = 1'b1;
                    w_inc_load = 1'b1;
                end
                if (w_step_nxt == 5'd16) begin
                    w_j_load   = 1'b1;
                    w_inc_load = 1'b1;
                end
                if (w_step_nxt inside {[5'd12:5'd13], [5'd17:5'd18]}) w_pc_load = 1'b1;
                if (w_cond_nxt && (w_step_nxt inside {[5'd20:5'd21]})) begin
                    w_addr_sel = 2'd3;
                    w_pc_load  = 1'b1;
                    w_pc_src   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.cycle_state = r_step;
    assign bus.halted      = r_halted;
    assign bus.addr_sel    = r_addr_sel;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.ir_load     = r_ir_load;
    assign bus.inc_load    = r_inc_load;
    assign bus.pc_load     = r_pc_load;
    assign bus.pc_src      = r_pc_src;
    assign bus.src_drive   = r_src_drive;
    assign bus.dst_load    = r_dst_load;
    assign bus.m_load      = r_m_load;
    assign bus.j_load      = r_j_load;
    assign bus.instr_done  = r_instr_done;

endmodule

// File: tb/tb_relay_instruction_sequencer.sv
// Self-checking bench for relay_instruction_sequencer: per-instruction strobe
// tables are painted from the timing rules and compared state by state.
module tb_relay_instruction_sequencer;

    localparam logic [7:0] HALT_OP = 8'b1010_1110;

    localparam int B_HALT = 0, B_DONE = 1, B_J = 2, B_M = 3, B_DST = 4, B_SRC = 5,
                   B_PCSRC = 6, B_PC = 7, B_INC = 8, B_IR = 9, B_MW = 10, B_MR = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    relay_instruction_sequencer_if #(.OPCODE_W(8)) bus ();

    relay_instruction_sequencer #(.OPCODE_W(8), .HALT_OPCODE(HALT_OP)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [13:0] exp_vec [0:24];
    int          exp_len;

    function automatic logic [13:0] observed();
        return {bus.addr_sel, bus.mem_read, bus.mem_write, bus.ir_load, bus.inc_load,
                bus.pc_load, bus.pc_src, bus.src_drive, bus.dst_load, bus.m_load,
                bus.j_load, bus.instr_done, bus.halted};
    endfunction

    task automatic paint(input int b, input int lo, input int hi);
        for (int s = lo; s <= hi; s++) exp_vec[s][b] = 1'b1;
    endtask

    task automatic set_addr(input logic [1:0] v, input int lo, input int hi);
        for (int s = lo; s <= hi; s++) exp_vec[s][13:12] = v;
    endtask

    // Reference timing table for one instruction, indexed by state 1..24.
    task automatic build_model(input logic [7:0] op, input logic cond);
        for (int s = 0; s <= 24; s++) exp_vec[s] = '0;
        set_addr(2'd1, 1, 3);
        paint(B_MR, 2, 3);
        paint(B_IR, 3, 3);
        paint(B_INC, 3, 3);
        paint(B_PC, 5, 6);
        if (op == HALT_OP) begin
            exp_len = 8;
        end else if (op[7:6] == 2'b11) begin
            exp_len = 24;
            set_addr(2'd1, 9, 11);
            set_addr(2'd1, 14, 16);
            paint(B_MR, 10, 11);
            paint(B_MR, 15, 16);
            paint(B_M, 11, 11);
            paint(B_INC, 11, 11);
            paint(B_J, 16, 16);
            paint(B_INC, 16, 16);
            paint(B_PC, 12, 13);
            paint(B_PC, 17, 18);
            if (cond) begin
                set_addr(2'd3, 20, 21);
                paint(B_PC, 20, 21);
                paint(B_PCSRC, 20, 21);
            end
        end else if (op[7:4] == 4'b1001) begin
            exp_len = 12;
            set_addr(2'd2, 9, 11);
            if (op[3]) begin
                paint(B_SRC, 9, 11);
                paint(B_MW, 10, 10);
            end else begin
                paint(B_MR, 10, 11);
                paint(B_DST, 11, 11);
            end
        end else if (op[7:6] != 2'b10 || op[7:4] == 4'b1000) begin
            exp_len = 8;
            paint(B_SRC, 5, 7);
            paint(B_DST, 7, 7);
        end else begin
            exp_len = 8;
        end
        paint(B_DONE, exp_len, exp_len);
    endtask

    // Expects the next rising edge to enter state 1. instr is only valid in
    // states 4 and cond_true only around state 19; elsewhere both are garbage.
    task automatic run_instr(input logic [7:0] op, input logic cond, input string tag);
        build_model(op, cond);
        bus.instr     = 8'($urandom);
        bus.cond_true = 1'($urandom);
        for (int k = 1; k <= exp_len; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.cycle_state !== 5'(k)) begin
                tests_failed++;
                $display("FAIL %s state_seq step %0d: got %0d want %0d", tag, k, bus.cycle_state, k);
            end
            tests_run++;
            if (observed() !== exp_vec[k]) begin
                tests_failed++;
                $display("FAIL %s strobes state %0d: got %b want %b", tag, k, observed(), exp_vec[k]);
            end
            tests_run++;
            if ((bus.mem_read & bus.mem_write) !== 1'b0 || (bus.pc_load & bus.ir_load) !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s exclusive state %0d: got mr=%b mw=%b pc=%b ir=%b want no overlap",
                         tag, k, bus.mem_read, bus.mem_write, bus.pc_load, bus.ir_load);
            end
            if (k == 3)  bus.instr = op;
            if (k == 5)  bus.instr = 8'($urandom);
            if (k == 18) bus.cond_true = cond;
            if (k == 20) bus.cond_true = 1'($urandom);
        end
        if (op == HALT_OP) begin
            @(negedge clk);
            tests_run++;
            if (bus.cycle_state !== 5'd0 || observed() !== 14'h0001) begin
                tests_failed++;
                $display("FAIL %s halt_entry: got state=%0d out=%b want state=0 out=%b",
                         tag, bus.cycle_state, observed(), 14'h0001);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        bus.instr = 8'h00;
        bus.cond_true = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.cycle_state !== 5'd0 || observed() !== 14'h0001) begin
            tests_failed++;
            $display("FAIL reset_state: got state=%0d out=%b want state=0 out=%b",
                     bus.cycle_state, observed(), 14'h0001);
        end
        bus.run = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.cycle_state !== 5'd0 || observed() !== 14'h0001) begin
            tests_failed++;
            $display("FAIL reset_beats_run: got state=%0d out=%b want state=0 out=%b",
                     bus.cycle_state, observed(), 14'h0001);
        end
        rst = 1'b0;
    endtask

    task automatic test_mov8();
        run_instr(8'h00, 1'b0, "mov8");
        run_instr(8'h47, 1'b1, "setab");
        run_instr(8'h85, 1'b0, "alu");
    endtask

    task automatic test_load_store();
        run_instr(8'b1001_0000, 1'b0, "load");
        run_instr(8'b1001_1000, 1'b1, "store");
    endtask

    task automatic test_goto();
        run_instr(8'hC0, 1'b1, "goto_taken");
        run_instr(8'hC0, 1'b0, "goto_not_taken");
    endtask

    task automatic test_nop();
        run_instr(8'hA0, 1'b1, "nop_a0");
        run_instr(8'hBF, 1'b0, "nop_bf");
    endtask

    task automatic test_halt();
        bus.run = 1'b0;
        run_instr(HALT_OP, 1'b0, "halt");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.cycle_state !== 5'd0 || bus.halted !== 1'b1) begin
                tests_failed++;
                $display("FAIL halt_hold cycle %0d: got state=%0d halted=%b want state=0 halted=1",
                         i, bus.cycle_state, bus.halted);
            end
        end
        bus.run = 1'b1;
        run_instr(8'h12, 1'b0, "resume_after_halt");
    endtask

    task automatic test_back_to_back();
        logic [7:0] op;
        for (int i = 0; i < 25; i++) begin
            op = 8'($urandom);
            if ($urandom_range(0, 5) == 0) op = HALT_OP;
            run_instr(op, 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_goto();
        int waited;
        build_model(8'hC3, 1'b1);
        bus.instr = 8'hC3;
        bus.cond_true = 1'b1;
        waited = 0;
        while (bus.cycle_state !== 5'd15 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (bus.cycle_state !== 5'd15) begin
            tests_failed++;
            $display("FAIL mid_goto_reach: got state=%0d want 15", bus.cycle_state);
        end
        tests_run++;
        if (observed() !== exp_vec[15]) begin
            tests_failed++;
            $display("FAIL mid_goto_strobes: got %b want %b", observed(), exp_vec[15]);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.cycle_state !== 5'd0 || observed() !== 14'h0001) begin
            tests_failed++;
            $display("FAIL async_reset: got state=%0d out=%b want state=0 out=%b",
                     bus.cycle_state, observed(), 14'h0001);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.cycle_state !== 5'd0 || observed() !== 14'h0001) begin
            tests_failed++;
            $display("FAIL reset_hold_run: got state=%0d out=%b want state=0 out=%b",
                     bus.cycle_state, observed(), 14'h0001);
        end
        rst = 1'b0;
        run_instr(8'h90, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_mov8();
        test_load_store();
        test_goto();
        test_nop();
        test_halt();
        test_back_to_back();
        test_reset_mid_goto();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
